slow_dac_pwm_meas: RTL and testbench

Measurement side of the 4-channel slow-DAC PWM output. It samples four PWM lines, taken from the board pins for loopback self-test or from external PWM sources. Over one update window of NFRM frames of PWM_FULL cycles each, it counts high cycles and rising edges per channel. The window is aligned to the generator's PWM sync pulse, so a static 24-bit setting {v[7:0], b[15:0]} reads back as high-sum = NFRM*v + popcount(b), as long as v+1 < PWM_FULL.

---
 rtl/slow_dac_pwm_meas_if.sv | 32 +++
 rtl/slow_dac_pwm_meas.sv | 166 ++++++++++++++++
 tb/tb_slow_dac_pwm_meas.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/slow_dac_pwm_meas_if.sv
// Signal bundle between the slow-DAC PWM measurement block and its client:
// enable/sync/PWM inputs and the per-window result outputs.
interface slow_dac_pwm_meas_if;
  logic        en_i;
  logic        sync_i;
  logic [3:0]  pwm_i;
  logic [11:0] sum_a_o;
  logic [11:0] sum_b_o;
  logic [11:0] sum_c_o;
  logic [11:0] sum_d_o;
  logic [7:0]  rise_a_o;
  logic [7:0]  rise_b_o;
  logic [7:0]  rise_c_o;
  logic [7:0]  rise_d_o;
  logic        valid_o;
  logic        aligned_o;
  logic        sync_err_o;

  modport slave (
    input  en_i, sync_i, pwm_i,
    output sum_a_o, sum_b_o, sum_c_o, sum_d_o,
    output rise_a_o, rise_b_o, rise_c_o, rise_d_o,
    output valid_o, aligned_o, sync_err_o
  );

  modport master (
    output en_i, sync_i, pwm_i,
    input  sum_a_o, sum_b_o, sum_c_o, sum_d_o,
    input  rise_a_o, rise_b_o, rise_c_o, rise_d_o,
    input  valid_o, aligned_o, sync_err_o
  );
endinterface

// File: rtl/slow_dac_pwm_meas.sv
// Slow-DAC PWM measurement: per-channel high-cycle and rising-edge counts over a
// sync-aligned window of NFRM PWM frames.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | disabled; accumulators and position held at zero
// WAIT_SYNC | enabled, waiting for the generator sync pulse
// DELAY     | counting down from sync to the first window sample
// RUN       | accumulating; window wraps every NFRM*PWM_FULL cycles
module slow_dac_pwm_meas #(
  parameter int PWM_FULL    = 156,
  parameter int NFRM        = 16,
  parameter int SYNC_DLY    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 dac_2clk_i,
  input  logic                 dac_rst_i,
  slow_dac_pwm_meas_if.slave   bus
);

  localparam int W     = NFRM * PWM_FULL;
  localparam int POS_W = 12;
  localparam int DLY_W = $clog2(PWM_FULL);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(W - 1);
  localparam logic [POS_W-1:0] POS_SYNC = POS_W'(W - SYNC_DLY);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, DELAY, RUN} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_sync [SYNC_STAGES];
  logic [3:0]         r_s_d;
  logic [3:0]         w_s;
  logic [3:0]         w_edge;
  logic [POS_W-1:0]   r_pos;
  logic [DLY_W-1:0]   r_dly;
  logic [11:0]        r_acc  [4];
  logic [7:0]         r_rcnt [4];
  logic [11:0]        r_sum  [4];
  logic [7:0]         r_rise [4];
  logic               r_valid;
  logic               r_err;
  logic               w_start;
  logic               w_clr;
  logic               w_acc_en;
  logic               w_commit;
  logic               w_err_set;
  logic               w_dly_dec;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_edge = w_s & ~r_s_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic e);
    return (e && (c != 8'hFF)) ? c + 8'd1 : c;
  endfunction

  always_ff @(posedge dac_2clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // r_dly holds the number of DELAY cycles left, including the current one.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_clr     = 1'b0;
    w_acc_en  = 1'b0;
    w_commit  = 1'b0;
    w_err_set = 1'b0;
    w_dly_dec = 1'b0;
    if (!bus.en_i) begin
      w_next = IDLE;
      w_clr  = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_clr  = 1'b1;
          w_next = WAIT_SYNC;
        end
        WAIT_SYNC: begin
          if (bus.sync_i) w_start = 1'b1;
        end
        DELAY: begin
          if (bus.sync_i)                   w_start = 1'b1;
          else if (r_dly <= DLY_W'(1))      w_next  = RUN;
          else                              w_dly_dec = 1'b1;
        end
        RUN: begin
          if (bus.sync_i && (r_pos != POS_SYNC)) begin
            w_err_set = 1'b1;
            w_start   = 1'b1;
            w_clr     = 1'b1;
          end else if (r_pos == POS_LAST) begin
            w_commit = 1'b1;
            w_clr    = 1'b1;
          end else begin
            w_acc_en = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
      if (w_start) w_next = (SYNC_DLY == 1) ? RUN : DELAY;
    end
  end

  always_ff @(posedge dac_2clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_s_d   <= '0;
      r_pos   <= '0;
      r_dly   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
        r_acc[ch]  <= '0;
        r_rcnt[ch] <= '0;
        r_sum[ch]  <= '0;
        r_rise[ch] <= '0;
      end
    end else begin
      r_sync[0] <= bus.pwm_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_s_d   <= w_s;
      r_valid <= w_commit;
      if (w_err_set) r_err <= 1'b1;

      if (w_start)        r_dly <= DLY_W'(SYNC_DLY - 1);
      else if (w_dly_dec) r_dly <= r_dly - DLY_W'(1);

      if (w_clr) begin
        r_pos <= '0;
        for (int ch = 0; ch < 4; ch++) begin
          r_acc[ch]  <= '0;
          r_rcnt[ch] <= '0;
        end
      end else if (w_acc_en) begin
        r_pos <= r_pos + POS_W'(1);
        for (int ch = 0; ch < 4; ch++) begin
          r_acc[ch]  <= r_acc[ch] + {11'b0, w_s[ch]};
          r_rcnt[ch] <= sat_inc(r_rcnt[ch], w_edge[ch]);
        end
      end

      // The last window sample is folded in on the way to the outputs.
      if (w_commit) begin
        for (int ch = 0; ch < 4; ch++) begin
          r_sum[ch]  <= r_acc[ch] + {11'b0, w_s[ch]};
          r_rise[ch] <= sat_inc(r_rcnt[ch], w_edge[ch]);
        end
      end
    end
  end

  assign bus.sum_a_o    = r_sum[0];
  assign bus.sum_b_o    = r_sum[1];
  assign bus.sum_c_o    = r_sum[2];
  assign bus.sum_d_o    = r_sum[3];
  assign bus.rise_a_o   = r_rise[0];
  assign bus.rise_b_o   = r_rise[1];
  assign bus.rise_c_o   = r_rise[2];
  assign bus.rise_d_o   = r_rise[3];
  assign bus.valid_o    = r_valid;
  assign bus.aligned_o  = (r_state == RUN);
  assign bus.sync_err_o = r_err;

endmodule

// File: tb/tb_slow_dac_pwm_meas.sv
// Bench for slow_dac_pwm_meas: randomized PWM stimulus, window model built from
// sync timing and a pin history, scoreboard queue checked by a negedge monitor.
module tb_slow_dac_pwm_meas;
  localparam int PWM_FULL = 156;
  localparam int NFRM     = 16;
  localparam int SYNC_DLY = 5;
  localparam int STAGES   = 2;
  localparam int W        = NFRM * PWM_FULL;
  // generator sync placed so that frame 0 reaches the first window sample
  localparam int GEN_SYNC = W - (SYNC_DLY - STAGES);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  slow_dac_pwm_meas_if bus();

  slow_dac_pwm_meas #(
    .PWM_FULL(PWM_FULL), .NFRM(NFRM), .SYNC_DLY(SYNC_DLY), .SYNC_STAGES(STAGES)
  ) dut (
    .dac_2clk_i(clk),
    .dac_rst_i (rst),
    .bus       (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [3:0] hist [65536];

  typedef struct {
    int          cyc;
    logic [47:0] sums;
    logic [31:0] rises;
  } exp_t;
  exp_t q[$];

  typedef enum int {M_IDLE, M_WAIT, M_ARM} mstate_t;
  mstate_t     m_state  = M_IDLE;
  int          m_start  = 0;
  logic        m_err    = 1'b0;
  logic [47:0] m_last_s = '0;
  logic [31:0] m_last_r = '0;
  int          stray_cyc = -1;

  int          g = 0;
  int          mode = 0;
  logic [3:0]  pwm_const = 4'h0;
  logic [15:0] b_set = 16'h00FF;
  bit          en_drv = 1'b0;
  bit          gen_sync_en = 1'b1;
  bit          stray_req = 1'b0;
  bit          glitch_req = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [47:0] dut_sums();
    return {bus.sum_d_o, bus.sum_c_o, bus.sum_b_o, bus.sum_a_o};
  endfunction

  function automatic logic [31:0] dut_rises();
    return {bus.rise_d_o, bus.rise_c_o, bus.rise_b_o, bus.rise_a_o};
  endfunction

  // Window result straight from the pin history: sample cycle c sees pin value c-STAGES.
  task automatic push_exp(input int first, input int last);
    exp_t e;
    e.cyc = last + 1;
    for (int ch = 0; ch < 4; ch++) begin
      int hi = 0;
      int rs = 0;
      for (int c = first; c <= last; c++) begin
        logic cur;
        logic prv;
        cur = hist[(c - STAGES) & 16'hFFFF][ch];
        prv = hist[(c - STAGES - 1) & 16'hFFFF][ch];
        hi += int'(cur);
        if (cur && !prv) rs++;
      end
      if (rs > 255) rs = 255;
      e.sums[ch*12 +: 12] = 12'(hi);
      e.rises[ch*8 +: 8]  = 8'(rs);
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    bit exp_v;
    if (rst) begin
      q.delete();
      m_state  = M_IDLE;
      m_err    = 1'b0;
      m_last_s = '0;
      m_last_r = '0;
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL valid_missing: got none expected valid at cycle %0d", q[0].cyc);
        void'(q.pop_front());
      end
      exp_v = (q.size() > 0) && (q[0].cyc == cyc);
      chk("valid", 64'(bus.valid_o), 64'(exp_v));
      if (bus.valid_o && exp_v) begin
        chk("sums", 64'(dut_sums()), 64'(q[0].sums));
        chk("rises", 64'(dut_rises()), 64'(q[0].rises));
        m_last_s = q[0].sums;
        m_last_r = q[0].rises;
        if (stray_cyc >= 0) begin
          chk("stray_gap", 64'(cyc - stray_cyc), 64'(SYNC_DLY + W));
          stray_cyc = -1;
        end
        void'(q.pop_front());
      end else if (!bus.valid_o && !exp_v) begin
        chk("hold_sums", 64'(dut_sums()), 64'(m_last_s));
        chk("hold_rises", 64'(dut_rises()), 64'(m_last_r));
      end else if (exp_v) begin
        void'(q.pop_front());
      end
      chk("aligned", 64'(bus.aligned_o), 64'((m_state == M_ARM) && (cyc >= m_start)));
      chk("sync_err", 64'(bus.sync_err_o), 64'(m_err));

      if (!bus.en_i) begin
        m_state = M_IDLE;
      end else begin
        case (m_state)
          M_IDLE: m_state = M_WAIT;
          M_WAIT: if (bus.sync_i) begin
            m_state = M_ARM;
            m_start = cyc + SYNC_DLY;
          end
          default: begin
            if (cyc < m_start) begin
              if (bus.sync_i) m_start = cyc + SYNC_DLY;
            end else if (bus.sync_i && (cyc - m_start) != W - SYNC_DLY) begin
              m_err   = 1'b1;
              m_start = cyc + SYNC_DLY;
            end else if (cyc - m_start == W - 1) begin
              push_exp(m_start, cyc);
              m_start = cyc + 1;
            end
          end
        endcase
      end
    end
  end

  task automatic step();
    logic [3:0] p;
    @(posedge clk);
    #1;
    g = (g + 1) % W;
    if (mode == 1) begin
      p[0] = ((g % PWM_FULL) < (78 + int'(b_set[g / PWM_FULL])));
      p[1] = ($urandom_range(0, 3) == 0);
      p[2] = ($urandom_range(0, 3) == 0);
      p[3] = ($urandom_range(0, 1) == 0);
    end else begin
      p = pwm_const | (glitch_req ? 4'b0100 : 4'b0000);
    end
    bus.pwm_i  = p;
    bus.sync_i = (gen_sync_en && g == GEN_SYNC) || stray_req;
    bus.en_i   = en_drv;
    hist[cyc & 16'hFFFF] = p;
  endtask

  task automatic step_until(input int gv);
    do step(); while (g != gv);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sums"},    64'(dut_sums()), 64'd0);
    chk({tag, "_rises"},   64'(dut_rises()), 64'd0);
    chk({tag, "_valid"},   64'(bus.valid_o), 64'd0);
    chk({tag, "_aligned"}, 64'(bus.aligned_o), 64'd0);
    chk({tag, "_err"},     64'(bus.sync_err_o), 64'd0);
  endtask

  initial begin
    int gpos;
    for (int i = 0; i < 65536; i++) hist[i] = 4'h0;
    bus.en_i   = 1'b0;
    bus.sync_i = 1'b0;
    bus.pwm_i  = 4'h0;

    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;

    // generator loopback on ch a, random lines on b..d
    mode   = 1;
    en_drv = 1'b1;
    repeat (3 * W + 100) step();
    chk("gen_sum_a", 64'(bus.sum_a_o), 64'd1256);
    chk("gen_rise_a", 64'(bus.rise_a_o), 64'd16);
    chk("gen_err", 64'(bus.sync_err_o), 64'd0);

    mode      = 0;
    pwm_const = 4'hF;
    repeat (2 * W + 20) step();
    chk("all_high_sums", 64'(dut_sums()), 64'({4{12'd2496}}));
    chk("all_high_rises", 64'(dut_rises()), 64'd0);

    pwm_const = 4'h0;
    repeat (2 * W + 20) step();
    chk("all_low_sums", 64'(dut_sums()), 64'd0);
    chk("all_low_rises", 64'(dut_rises()), 64'd0);

    gpos = $urandom_range(200, 2200);
    step_until(gpos - 1);
    glitch_req = 1'b1;
    step();
    glitch_req = 1'b0;
    step_until(10);
    chk("glitch_sums", 64'(dut_sums()), 64'({12'd0, 12'd1, 12'd0, 12'd0}));
    chk("glitch_rises", 64'(dut_rises()), 64'({8'd0, 8'd1, 8'd0, 8'd0}));

    // drop enable on the last sample of a window
    step_until(0);
    en_drv = 1'b0;
    step();
    repeat (20) step();
    chk("en_off_aligned", 64'(bus.aligned_o), 64'd0);
    chk("en_off_sums", 64'(dut_sums()), 64'({12'd0, 12'd1, 12'd0, 12'd0}));
    en_drv = 1'b1;
    mode   = 1;
    repeat (2 * W + 20) step();

    // stray sync at window position 1000, generator syncs held off
    step_until(1001);
    stray_req   = 1'b1;
    gen_sync_en = 1'b0;
    step();
    stray_req = 1'b0;
    stray_cyc = cyc;
    repeat (W + 20) step();
    chk("stray_err", 64'(bus.sync_err_o), 64'd1);
    gen_sync_en = 1'b1;
    repeat (W + 20) step();
    chk("stray_err_sticky", 64'(bus.sync_err_o), 64'd1);

    // asynchronous reset in the middle of a window
    step_until(800);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    repeat (3) step();
    rst = 1'b0;
    repeat (2 * W + 20) step();
    chk("post_rst_err", 64'(bus.sync_err_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
